// File: rtl/dmem_access_m_if.sv
// Data-memory bus between the Memory-stage access unit (master) and the data memory (slave).
// Handshake: the master raises mem_req with stable mem_we/mem_addr/mem_wdata and keeps them until the
// slave returns a single-cycle mem_ack; mem_rdata is meaningful only in the mem_ack cycle.
interface dmem_access_m_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_access_m.sv
// Memory-stage data access unit: turns a load/store in M into one bus transaction and stalls the pipeline.
// Optional busy timeout with MemErr abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_m #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWriteM,
    input  logic [1:0]           ResultSrcM,
    input  logic [31:0]          ALUResultM,
    input  logic [31:0]          WriteDataM,
    dmem_access_m_if.master      bus,
    output logic                 StallMem,
    output logic [31:0]          ReadDataM,
    output logic                 MemErr,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        access;

    assign access = MemWriteM | (ResultSrcM == 2'b01);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        StallMem = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    StallMem = 1'b1;
                    state_d  = BUSY;
                    req_d    = 1'b1;
                    we_d     = MemWriteM;
                    addr_d   = ALUResultM;
                    wdata_d  = WriteDataM;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                StallMem = 1'b1;
                if (bus.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = bus.mem_rdata;
`ifdef DMEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: the load returns zero and MemErr marks the DONE cycle.
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            // DONE lets the held M instruction advance; never chain straight into a new access.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) StallMem = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef DMEM_TIMEOUT_EN
    assign MemErr = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign MemErr = 1'b0;
`endif

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign ReadDataM     = rdata_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_dmem_access_m.sv
// Directed bench for dmem_access_m: transaction-level model checked every cycle plus literal expectations.
module tb_dmem_access_m;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallMem;
    logic [31:0] ReadDataM;
    logic        MemErr;
    logic [1:0]  state_dbg;

    dmem_access_m_if bus();

    dmem_access_m #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .bus       (bus),
        .StallMem  (StallMem),
        .ReadDataM (ReadDataM),
        .MemErr    (MemErr),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        ALUResultM = $urandom;
        WriteDataM = $urandom;
    endtask

    // transaction-level model: one outstanding access, a one-cycle release slot, then idle
    bit          m_active = 0, m_done = 0, m_err = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0;
            m_we <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
        end else if (m_active) begin
            if (bus.mem_ack) begin
                m_active <= 0; m_done <= 1;
                if (!m_we) m_rdata <= bus.mem_rdata;
            end else begin
                m_cnt <= m_cnt + 1;
`ifdef DMEM_TIMEOUT_EN
                if (m_cnt + 1 == T) begin
                    m_active <= 0; m_done <= 1; m_err <= 1;
                    if (!m_we) m_rdata <= 0;
                end
`endif
            end
        end else if (m_done) begin
            m_done <= 0; m_err <= 0;
        end else if (MemWriteM || ResultSrcM == 2'b01) begin
            m_active <= 1; m_cnt <= 0;
            m_we <= MemWriteM; m_addr <= ALUResultM; m_wdata <= WriteDataM;
        end
    end

    // scoreboard: compare every cycle on the falling edge
    int   stall_total = 0, req_total = 0, dut_rises = 0;
    logic prev_req = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic acc;
            acc = !reset && (MemWriteM || ResultSrcM == 2'b01);
            check("stall", StallMem, !reset && (m_active || (!m_done && acc)));
            check("req", bus.mem_req, m_active);
            check("rdata_m", ReadDataM, m_rdata);
            check("memerr", MemErr, m_err);
            check("state", state_dbg, m_active ? 2'd1 : (m_done ? 2'd2 : 2'd0));
            if (m_active) begin
                check("bus_we", bus.mem_we, m_we);
                check("bus_addr", bus.mem_addr, m_addr);
                check("bus_wdata", bus.mem_wdata, m_wdata);
            end
            if (StallMem) stall_total++;
            if (bus.mem_req) req_total++;
            if (bus.mem_req && !prev_req) dut_rises++;
            prev_req = bus.mem_req;
        end
    end

    // driver: one access held in M until its DONE cycle; ack_at=0 means never ack
    task automatic do_access(input logic we, input logic [1:0] rs, input logic [31:0] addr,
                             input logic [31:0] data, input int ack_at, input logic [31:0] rd,
                             output int stalls, output int reqs);
        int s0, r0;
        s0 = stall_total;
        r0 = req_total;
        MemWriteM = we; ResultSrcM = rs; ALUResultM = addr; WriteDataM = data;
        tick();
        check("busy_we", bus.mem_we, we);
        check("busy_addr", bus.mem_addr, addr);
        check("busy_wdata", bus.mem_wdata, data);
        if (ack_at == 0) begin
            repeat (T) tick();
        end else begin
            repeat (ack_at - 1) tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = rd;
            tick();
            bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        end
        check("done_stall", StallMem, 1'b0);
        check("done_req", bus.mem_req, 1'b0);
        check("done_err", MemErr, ack_at == 0);
        tick();
        idle_inputs();
        stalls = stall_total - s0;
        reqs = req_total - r0;
    endtask

    initial begin
        int st, rq, rise0;
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        idle_inputs();
        tick();
        tick();
        mon_en = 1;
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_stall", StallMem, 1'b0);
        tick();
        reset = 1'b0;

        // load, ack in 3rd BUSY cycle
        do_access(1'b0, 2'b01, 32'h100, 32'h0, 3, 32'hDEADBEEF, st, rq);
        check("load_stalls", st, 4);
        check("load_reqs", rq, 3);
        check("load_data", ReadDataM, 32'hDEADBEEF);

        // spurious ack while idle
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("idle_ack_data", ReadDataM, 32'hDEADBEEF);

        // store, immediate ack
        do_access(1'b1, 2'b00, 32'h40, 32'h12345678, 1, 32'h99999999, st, rq);
        check("store_stalls", st, 2);
        check("store_reqs", rq, 1);
        check("store_keeps_data", ReadDataM, 32'hDEADBEEF);

        // store and load together: a single write
        do_access(1'b1, 2'b01, 32'h80, 32'hA5A5A5A5, 2, 32'h11111111, st, rq);
        check("both_reqs", rq, 2);
        check("both_keeps_data", ReadDataM, 32'hDEADBEEF);

        // back-to-back loads, unaligned address passed through
        rise0 = dut_rises;
        do_access(1'b0, 2'b01, 32'h203, 32'h0, 1, 32'hCAFE0001, st, rq);
        check("b2b_first", ReadDataM, 32'hCAFE0001);
        do_access(1'b0, 2'b01, 32'h204, 32'h0, 2, 32'hCAFE0002, st, rq);
        check("b2b_second", ReadDataM, 32'hCAFE0002);
        check("b2b_issues", dut_rises - rise0, 2);

        // reset in the 2nd BUSY cycle, then a late ack
        MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h300;
        tick();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        check("rst_busy_req", bus.mem_req, 1'b0);
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("rst_busy_state", state_dbg, 2'd0);
        check("rst_busy_data", ReadDataM, 32'h0);
        check("rst_busy_req2", bus.mem_req, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        do_access(1'b0, 2'b01, 32'h500, 32'h0, 1, 32'h5555AAAA, st, rq);
        check("pre_to_data", ReadDataM, 32'h5555AAAA);
        do_access(1'b0, 2'b01, 32'h504, 32'h0, 0, 32'h0, st, rq);
        check("to_stalls", st, 5);
        check("to_reqs", rq, 4);
        check("to_data", ReadDataM, 32'h0);
        check("to_err_clear", MemErr, 1'b0);
        do_access(1'b0, 2'b01, 32'h508, 32'h0, 4, 32'h13572468, st, rq);
        check("ack4_data", ReadDataM, 32'h13572468);
`endif

        tick();
        tick();
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
